// File: rtl/max_select_pipe_pkg.sv
// max_select_pipe_pkg: shared clog2, lane-slice macro and accumulator state encodings.
package max_select_pipe_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} acc_state_e;
endpackage

`ifndef MSP_LANE
`define MSP_LANE(bus, i, w) bus[(i)*(w) +: (w)]
`endif

// File: rtl/max_select_node.sv
// max_select_node: registered 2-input compare (ties go to a); min select only with MAX_SELECT_MIN_MODE_EN.
module max_select_node #(
  parameter int DATA_W = 4,
  parameter int IDX_W  = 2
) (
  input  logic              CLK,
  input  logic              RESET_L,
`ifdef MAX_SELECT_MIN_MODE_EN
  input  logic              min_sel_i,
  output logic              min_sel_o,
`endif
  input  logic              in_vld,
  input  logic [DATA_W-1:0] a_val,
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [DATA_W-1:0] b_val,
  input  logic [IDX_W-1:0]  b_idx,
  output logic              vld_o,
  output logic [DATA_W-1:0] val_o,
  output logic [IDX_W-1:0]  idx_o
);
  logic              vld_q, vld_d, pick_b;
  logic [DATA_W-1:0] val_q, val_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
`ifdef MAX_SELECT_MIN_MODE_EN
  logic ms_q, ms_d;
  assign min_sel_o = ms_q;
`endif
  always_comb begin
`ifdef MAX_SELECT_MIN_MODE_EN
    pick_b = min_sel_i ? (b_val < a_val) : (b_val > a_val);
    ms_d   = in_vld ? min_sel_i : ms_q;
`else
    pick_b = b_val > a_val;
`endif
    vld_d = in_vld;
    val_d = in_vld ? (pick_b ? b_val : a_val) : val_q;
    idx_d = in_vld ? (pick_b ? b_idx : a_idx) : idx_q;
  end
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      vld_q <= 1'b0;
      val_q <= '0;
      idx_q <= '0;
`ifdef MAX_SELECT_MIN_MODE_EN
      ms_q  <= 1'b0;
`endif
    end else begin
      vld_q <= vld_d;
      val_q <= val_d;
      idx_q <= idx_d;
`ifdef MAX_SELECT_MIN_MODE_EN
      ms_q  <= ms_d;
`endif
    end
  end
  assign vld_o = vld_q;
  assign val_o = val_q;
  assign idx_o = idx_q;
endmodule

// File: rtl/max_select_pipe.sv
// max_select_pipe: pipelined max-select tree plus frame accumulator.
// MAX_SELECT_MIN_MODE_EN adds MIN_SEL to select minimum instead.
module max_select_pipe import max_select_pipe_pkg::*; #(
  parameter  int DATA_W = 4,
  parameter  int NUM_IN = 4,
  parameter  int CNT_W  = 8,
  localparam int LVL    = clog2(NUM_IN),
  localparam int IDX_W  = LVL
) (
  input  logic                     CLK,
  input  logic                     RESET_L,
`ifdef MAX_SELECT_MIN_MODE_EN
  input  logic                     MIN_SEL,
`endif
  input  logic                     IN_VALID,
  input  logic                     IN_LAST,
  input  logic [NUM_IN*DATA_W-1:0] IN_DATA,
  output logic                     OUT_VALID,
  output logic [DATA_W-1:0]        OUT_MAX,
  output logic [IDX_W-1:0]         OUT_IDX,
  output logic                     FRAME_VALID,
  output logic [DATA_W-1:0]        FRAME_MAX,
  output logic [IDX_W-1:0]         FRAME_IDX,
  output logic [CNT_W-1:0]         FRAME_CNT
);
  // Heap layout: node n has children 2n (lower lanes) and 2n+1; leaves are NUM_IN..2*NUM_IN-1.
  logic [DATA_W-1:0] val [1:2*NUM_IN-1];
  logic [IDX_W-1:0]  idx [1:2*NUM_IN-1];
  logic              vld [1:2*NUM_IN-1];
`ifdef MAX_SELECT_MIN_MODE_EN
  logic              ms  [1:2*NUM_IN-1];
`endif
  for (genvar g = 0; g < NUM_IN; g++) begin : g_leaf
    assign val[NUM_IN+g] = `MSP_LANE(IN_DATA, g, DATA_W);
    assign idx[NUM_IN+g] = IDX_W'(g);
    assign vld[NUM_IN+g] = IN_VALID;
`ifdef MAX_SELECT_MIN_MODE_EN
    assign ms[NUM_IN+g]  = MIN_SEL;
`endif
  end
  for (genvar n = 1; n < NUM_IN; n++) begin : g_node
    max_select_node #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_node (
      .CLK       (CLK),
      .RESET_L   (RESET_L),
`ifdef MAX_SELECT_MIN_MODE_EN
      .min_sel_i (ms[2*n]),
      .min_sel_o (ms[n]),
`endif
      .in_vld    (vld[2*n] & vld[2*n+1]),
      .a_val     (val[2*n]),
      .a_idx     (idx[2*n]),
      .b_val     (val[2*n+1]),
      .b_idx     (idx[2*n+1]),
      .vld_o     (vld[n]),
      .val_o     (val[n]),
      .idx_o     (idx[n])
    );
  end
  assign OUT_VALID = vld[1];
  assign OUT_MAX   = val[1];
  assign OUT_IDX   = idx[1];
  logic [LVL-1:0]    last_q, last_d;
  acc_state_e        state_q, state_d;
  logic [DATA_W-1:0] acc_max_q, acc_max_d, fmax_q, fmax_d, m_max;
  logic [IDX_W-1:0]  acc_idx_q, acc_idx_d, fidx_q, fidx_d, m_idx;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d, fcnt_q, fcnt_d, m_cnt;
  logic              fv_q, fv_d, better, take, root_last;
  always_comb begin
    last_d    = LVL'({last_q, IN_VALID & IN_LAST});
    root_last = last_q[LVL-1];
`ifdef MAX_SELECT_MIN_MODE_EN
    better = ms[1] ? (val[1] < acc_max_q) : (val[1] > acc_max_q);
`else
    better = val[1] > acc_max_q;
`endif
    take      = (state_q == IDLE) || better;
    m_max     = take ? val[1] : acc_max_q;
    m_idx     = take ? idx[1] : acc_idx_q;
    m_cnt     = (state_q == IDLE) ? CNT_W'(1) : (&acc_cnt_q ? acc_cnt_q : acc_cnt_q + 1'b1);
    state_d   = vld[1] ? (root_last ? IDLE : ACC) : state_q;
    acc_max_d = vld[1] ? m_max : acc_max_q;
    acc_idx_d = vld[1] ? m_idx : acc_idx_q;
    acc_cnt_d = vld[1] ? m_cnt : acc_cnt_q;
    fv_d      = vld[1] & root_last;
    fmax_d    = fv_d ? m_max : fmax_q;
    fidx_d    = fv_d ? m_idx : fidx_q;
    fcnt_d    = fv_d ? m_cnt : fcnt_q;
  end
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      last_q    <= '0;
      state_q   <= IDLE;
      acc_max_q <= '0;
      acc_idx_q <= '0;
      acc_cnt_q <= '0;
      fv_q      <= 1'b0;
      fmax_q    <= '0;
      fidx_q    <= '0;
      fcnt_q    <= '0;
    end else begin
      last_q    <= last_d;
      state_q   <= state_d;
      acc_max_q <= acc_max_d;
      acc_idx_q <= acc_idx_d;
      acc_cnt_q <= acc_cnt_d;
      fv_q      <= fv_d;
      fmax_q    <= fmax_d;
      fidx_q    <= fidx_d;
      fcnt_q    <= fcnt_d;
    end
  end
  assign FRAME_VALID = fv_q;
  assign FRAME_MAX   = fmax_q;
  assign FRAME_IDX   = fidx_q;
  assign FRAME_CNT   = fcnt_q;
endmodule

// File: tb/tb_max_select_pipe.sv
// tb_max_select_pipe: directed checks of the default build and an 8-lane, CNT_W=2 variant.
module tb_max_select_pipe;
  logic        CLK = 1'b0, RESET_L = 1'b0;
  logic        iv, il, ov, fv;
  logic [15:0] id;
  logic [3:0]  om, fm;
  logic [1:0]  oi, fi;
  logic [7:0]  fc;
  logic        iv2, il2, ov2, fv2;
  logic [63:0] id2;
  logic [7:0]  om2, fm2;
  logic [2:0]  oi2, fi2;
  logic [1:0]  fc2;
  int          n_vec = 0, n_err = 0;
`ifdef MAX_SELECT_MIN_MODE_EN
  logic        ms = 1'b0, ms2 = 1'b0;
`endif
  always #5 CLK = ~CLK;

  max_select_pipe dut (
    .CLK(CLK), .RESET_L(RESET_L),
`ifdef MAX_SELECT_MIN_MODE_EN
    .MIN_SEL(ms),
`endif
    .IN_VALID(iv), .IN_LAST(il), .IN_DATA(id),
    .OUT_VALID(ov), .OUT_MAX(om), .OUT_IDX(oi),
    .FRAME_VALID(fv), .FRAME_MAX(fm), .FRAME_IDX(fi), .FRAME_CNT(fc)
  );

  max_select_pipe #(.DATA_W(8), .NUM_IN(8), .CNT_W(2)) dut2 (
    .CLK(CLK), .RESET_L(RESET_L),
`ifdef MAX_SELECT_MIN_MODE_EN
    .MIN_SEL(ms2),
`endif
    .IN_VALID(iv2), .IN_LAST(il2), .IN_DATA(id2),
    .OUT_VALID(ov2), .OUT_MAX(om2), .OUT_IDX(oi2),
    .FRAME_VALID(fv2), .FRAME_MAX(fm2), .FRAME_IDX(fi2), .FRAME_CNT(fc2)
  );

  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    n_vec++;
    if (o !== e) begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", t, o, e);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [15:0] d);
    iv = v;
    il = l;
    id = d;
  endtask

  logic [63:0] sv [5];

  initial begin
    sv = '{64'h0000_0000_0000_0020, 64'h0000_0000_5000_0000, 64'h5000_0000_0000_0000,
           64'h0000_0000_0000_3000, 64'h0040_0000_0000_0000};
    drive(1, 1, 16'hFFFF);
    iv2 = 1; il2 = 1; id2 = '1;
    RESET_L = 0;
    tick(3);
    chk("rst_ov", ov, 1'b0);
    chk("rst_om", om, 4'h0);
    chk("rst_oi", oi, 2'd0);
    chk("rst_fv", fv, 1'b0);
    chk("rst_fm", fm, 4'h0);
    chk("rst_fc", fc, 8'd0);
    chk("rst_ov2", ov2, 1'b0);
    chk("rst_fc2", fc2, 2'd0);
    RESET_L = 1;
    drive(0, 0, 16'h0);
    iv2 = 0; il2 = 0; id2 = '0;
    tick(3);
    chk("post_rst_ov", ov, 1'b0);
    chk("post_rst_fv", fv, 1'b0);
    chk("post_rst_ov2", ov2, 1'b0);

    drive(1, 1, 16'h3A52);
    tick;
    drive(0, 0, 16'h0);
    chk("single_early_ov", ov, 1'b0);
    tick;
    chk("single_ov", ov, 1'b1);
    chk("single_om", om, 4'hA);
    chk("single_oi", oi, 2'd2);
    chk("single_early_fv", fv, 1'b0);
    tick;
    chk("single_ov_pulse", ov, 1'b0);
    chk("single_fv", fv, 1'b1);
    chk("single_fm", fm, 4'hA);
    chk("single_fi", fi, 2'd2);
    chk("single_fc", fc, 8'd1);
    tick;
    chk("single_fv_pulse", fv, 1'b0);
    chk("single_fm_hold", fm, 4'hA);

    drive(1, 1, 16'h7717);
    tick;
    drive(0, 0, 16'h0);
    tick;
    chk("tie_a_om", om, 4'h7);
    chk("tie_a_oi", oi, 2'd0);
    drive(1, 1, 16'h7170);
    tick;
    drive(0, 0, 16'h0);
    tick;
    chk("tie_b_om", om, 4'h7);
    chk("tie_b_oi", oi, 2'd1);
    tick;
    drive(1, 0, 16'h0900);
    tick;
    drive(1, 1, 16'h9000);
    tick;
    drive(0, 0, 16'h0);
    tick;
    chk("tie_frame_early_fv", fv, 1'b0);
    tick;
    chk("tie_frame_fv", fv, 1'b1);
    chk("tie_frame_fm", fm, 4'h9);
    chk("tie_frame_fi", fi, 2'd2);
    chk("tie_frame_fc", fc, 8'd2);

    drive(1, 1, 16'h1111);
    tick;
    drive(1, 0, 16'h2222);
    tick;
    chk("b2b_ov0", ov, 1'b1);
    chk("b2b_om0", om, 4'h1);
    chk("b2b_oi0", oi, 2'd0);
    drive(1, 1, 16'hF000);
    tick;
    chk("b2b_ov1", ov, 1'b1);
    chk("b2b_om1", om, 4'h2);
    chk("b2b_fv0", fv, 1'b1);
    chk("b2b_fm0", fm, 4'h1);
    chk("b2b_fi0", fi, 2'd0);
    chk("b2b_fc0", fc, 8'd1);
    drive(0, 0, 16'h0);
    tick;
    chk("b2b_ov2", ov, 1'b1);
    chk("b2b_om2", om, 4'hF);
    chk("b2b_oi2", oi, 2'd3);
    chk("b2b_fv_gap", fv, 1'b0);
    tick;
    chk("b2b_ov_end", ov, 1'b0);
    chk("b2b_fv1", fv, 1'b1);
    chk("b2b_fm1", fm, 4'hF);
    chk("b2b_fi1", fi, 2'd3);
    chk("b2b_fc1", fc, 8'd2);

    drive(1, 0, 16'h000F);
    tick;
    drive(1, 0, 16'h00F0);
    tick;
    RESET_L = 0;
    drive(0, 0, 16'h0);
    tick;
    chk("midrst_ov", ov, 1'b0);
    chk("midrst_fv", fv, 1'b0);
    chk("midrst_fm", fm, 4'h0);
    chk("midrst_fc", fc, 8'd0);
    RESET_L = 1;
    drive(1, 1, 16'h0004);
    tick;
    drive(0, 0, 16'h0);
    chk("midrst_no_stale_ov", ov, 1'b0);
    tick;
    chk("midrst_ov1", ov, 1'b1);
    chk("midrst_om", om, 4'h4);
    chk("midrst_fv_early", fv, 1'b0);
    tick;
    chk("midrst_fv1", fv, 1'b1);
    chk("midrst_fm1", fm, 4'h4);
    chk("midrst_fc1", fc, 8'd1);

    iv2 = 1; il2 = 1; id2 = 64'h0102_C304_0506_0708;
    tick;
    iv2 = 0; il2 = 0; id2 = '0;
    tick;
    chk("w8_early_ov", ov2, 1'b0);
    tick;
    chk("w8_ov", ov2, 1'b1);
    chk("w8_om", om2, 8'hC3);
    chk("w8_oi", oi2, 3'd5);
    tick;
    chk("w8_fv", fv2, 1'b1);
    chk("w8_fm", fm2, 8'hC3);
    chk("w8_fc", fc2, 2'd1);

    for (int i = 0; i < 5; i++) begin
      iv2 = 1; il2 = (i == 4); id2 = sv[i];
      tick;
    end
    iv2 = 0; il2 = 0; id2 = '0;
    tick(2);
    chk("sat_early_fv", fv2, 1'b0);
    tick;
    chk("sat_fv", fv2, 1'b1);
    chk("sat_fm", fm2, 8'h50);
    chk("sat_fi", fi2, 3'd3);
    chk("sat_fc", fc2, 2'd3);

`ifdef MAX_SELECT_MIN_MODE_EN
    ms = 1;
    drive(1, 1, 16'h3A52);
    tick;
    ms = 0;
    drive(0, 0, 16'h0);
    tick;
    chk("min_om", om, 4'h2);
    chk("min_oi", oi, 2'd0);
    tick;
    chk("min_fm", fm, 4'h2);
    chk("min_fi", fi, 2'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
